// File: rtl/hazard_ctrl.sv
// Stall/bubble controller for the 5-stage MIPS core: Tuse/Tnew scoreboard for E and M,
// plus the multi-cycle mult/div busy counter that holds HI/LO traffic in D.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_Instr,
    output logic        stall,
    output logic        flush_E,
    output logic        md_start,
    output logic        md_busy
);
    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ORI = 6'h0d;
    localparam logic [5:0] OP_LUI = 6'h0f;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1a;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign op = D_Instr[31:26];
    assign rs = D_Instr[25:21];
    assign rt = D_Instr[20:16];
    assign rd = D_Instr[15:11];
    assign fn = D_Instr[5:0];
    assign unused_shamt = ^D_Instr[10:6];

    // D-stage decode
    logic       rs_used, rt_used;
    logic [1:0] rs_tuse, rt_tuse;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic       d_md_class, d_mult, d_div;

    always_comb begin
        rs_used    = 1'b0;
        rt_used    = 1'b0;
        rs_tuse    = 2'd0;
        rt_tuse    = 2'd0;
        d_dst      = 5'd0;
        d_tnew     = 2'd0;
        d_md_class = 1'b0;
        d_mult     = 1'b0;
        d_div      = 1'b0;
        case (op)
            OP_R: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        rs_used = 1'b1; rs_tuse = 2'd1;
                        rt_used = 1'b1; rt_tuse = 2'd1;
                        d_dst   = rd;   d_tnew  = 2'd1;
                    end
                    FN_JR: begin
                        rs_used = 1'b1; rs_tuse = 2'd0;
                    end
                    FN_MULT, FN_DIV: begin
                        rs_used    = 1'b1; rs_tuse = 2'd1;
                        rt_used    = 1'b1; rt_tuse = 2'd1;
                        d_md_class = 1'b1;
                        d_mult     = (fn == FN_MULT);
                        d_div      = (fn == FN_DIV);
                    end
                    FN_MFHI, FN_MFLO: begin
                        d_dst      = rt; d_tnew = 2'd1;
                        d_md_class = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        rs_used    = 1'b1; rs_tuse = 2'd1;
                        d_md_class = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                rs_used = 1'b1; rs_tuse = 2'd1;
                d_dst   = rt;   d_tnew  = 2'd1;
            end
            OP_LW: begin
                rs_used = 1'b1; rs_tuse = 2'd1;
                d_dst   = rt;   d_tnew  = 2'd2;
            end
            OP_SW: begin
                rs_used = 1'b1; rs_tuse = 2'd1;
                rt_used = 1'b1; rt_tuse = 2'd2;
            end
            OP_BEQ: begin
                rs_used = 1'b1; rs_tuse = 2'd0;
                rt_used = 1'b1; rt_tuse = 2'd0;
            end
            OP_LUI: begin
                d_dst = rt; d_tnew = 2'd1;
            end
            OP_JAL: begin
                d_dst = 5'd31; d_tnew = 2'd0;
            end
            default: ;
        endcase
    end

    // Shadow scoreboard for E and M; W always forwards in time
    logic [4:0]       e_dst, m_dst;
    logic [1:0]       e_tnew, m_tnew;
    logic             e_mult, e_div;
    logic [CNT_W-1:0] md_cnt;

    logic rs_haz, rt_haz, md_haz;

    assign rs_haz = rs_used && (rs != 5'd0) &&
                    (((e_dst == rs) && (e_tnew > rs_tuse)) ||
                     ((m_dst == rs) && (m_tnew > rs_tuse)));
    assign rt_haz = rt_used && (rt != 5'd0) &&
                    (((e_dst == rt) && (e_tnew > rt_tuse)) ||
                     ((m_dst == rt) && (m_tnew > rt_tuse)));

    assign md_start = e_mult | e_div;
    assign md_busy  = md_start | (md_cnt != '0);
    assign md_haz   = d_md_class & md_busy;
    assign stall    = rs_haz | rt_haz | md_haz;
    assign flush_E  = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_dst  <= 5'd0;
            e_tnew <= 2'd0;
            e_mult <= 1'b0;
            e_div  <= 1'b0;
            m_dst  <= 5'd0;
            m_tnew <= 2'd0;
            md_cnt <= '0;
        end else begin
            if (stall) begin
                e_dst  <= 5'd0;
                e_tnew <= 2'd0;
                e_mult <= 1'b0;
                e_div  <= 1'b0;
            end else begin
                e_dst  <= d_dst;
                e_tnew <= d_tnew;
                e_mult <= d_mult;
                e_div  <= d_div;
            end
            // M keeps advancing even while D is held
            m_dst  <= e_dst;
            m_tnew <= (e_tnew != 2'd0) ? e_tnew - 2'd1 : 2'd0;
            if (md_start)
                md_cnt <= e_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: a per-register "result ready at cycle" model
// predicts stall/md outputs; a negedge monitor pops and compares every cycle.
module tb_hazard_ctrl;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ORI = 6'h0d,
                           OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_JR = 6'h08, FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12,
                           FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_DIV = 6'h1a,
                           FN_ADDU = 6'h21, FN_SUBU = 6'h23;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] D_Instr = 32'd0;
    logic        stall, flush_E, md_start, md_busy;

    hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .D_Instr(D_Instr),
        .stall(stall), .flush_E(flush_E), .md_start(md_start), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic st; logic ms; logic mb; } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int ready[32];
    int md_until = -100;
    int md_start_at = -100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt);
        return {op, 5'(rs), 5'(rt), 16'h0010};
    endfunction

    // Architectural view: which regs each instr reads (with Tuse) and writes (with Tnew)
    task automatic decode(input logic [31:0] ins, output int s1, output int u1,
                          output int s2, output int u2, output int dst, output int tnew,
                          output bit mdc, output bit mul, output bit dv);
        int rs, rt, rd;
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        s1 = 0; u1 = -1; s2 = 0; u2 = -1; dst = 0; tnew = 0; mdc = 0; mul = 0; dv = 0;
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                FN_ADDU, FN_SUBU: begin s1 = rs; u1 = 1; s2 = rt; u2 = 1; dst = rd; tnew = 1; end
                FN_JR:            begin s1 = rs; u1 = 0; end
                FN_MULT:          begin s1 = rs; u1 = 1; s2 = rt; u2 = 1; mdc = 1; mul = 1; end
                FN_DIV:           begin s1 = rs; u1 = 1; s2 = rt; u2 = 1; mdc = 1; dv = 1; end
                FN_MFHI, FN_MFLO: begin dst = rt; tnew = 1; mdc = 1; end
                FN_MTHI, FN_MTLO: begin s1 = rs; u1 = 1; mdc = 1; end
                default: ;
            endcase
        end else begin
            case (ins[31:26])
                OP_ORI: begin s1 = rs; u1 = 1; dst = rt; tnew = 1; end
                OP_LW:  begin s1 = rs; u1 = 1; dst = rt; tnew = 2; end
                OP_SW:  begin s1 = rs; u1 = 1; s2 = rt; u2 = 2; end
                OP_BEQ: begin s1 = rs; u1 = 0; s2 = rt; u2 = 0; end
                OP_LUI: begin dst = rt; tnew = 1; end
                OP_JAL: begin dst = 31; tnew = 0; end
                default: ;
            endcase
        end
    endtask

    // A consumer in D at cycle c needing r at Tuse u is fine once c+u >= ready[r]
    task automatic model_eval(input logic [31:0] ins, output bit st);
        int s1, u1, s2, u2, dst, tnew;
        bit mdc, mul, dv, gpr;
        decode(ins, s1, u1, s2, u2, dst, tnew, mdc, mul, dv);
        gpr = (s1 != 0 && u1 >= 0 && cyc + u1 < ready[s1]) ||
              (s2 != 0 && u2 >= 0 && cyc + u2 < ready[s2]);
        st = gpr || (mdc && cyc <= md_until);
    endtask

    task automatic model_commit(input logic [31:0] ins, input bit st);
        int s1, u1, s2, u2, dst, tnew;
        bit mdc, mul, dv;
        decode(ins, s1, u1, s2, u2, dst, tnew, mdc, mul, dv);
        if (!st) begin
            if (dst != 0 && cyc + 1 + tnew > ready[dst]) ready[dst] = cyc + 1 + tnew;
            if (mul) begin md_start_at = cyc + 1; md_until = cyc + 1 + MULT_CYCLES; end
            if (dv)  begin md_start_at = cyc + 1; md_until = cyc + 1 + DIV_CYCLES;  end
        end
        cyc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ready[i] = 0;
        md_until = -100;
        md_start_at = -100;
    endtask

    task automatic cycle(input logic [31:0] ins, output bit st);
        exp_t e;
        D_Instr = ins;
        model_eval(ins, st);
        e.st = st;
        e.ms = (cyc == md_start_at);
        e.mb = (cyc <= md_until);
        exp_q.push_back(e);
        @(posedge clk); #1;
        model_commit(ins, st);
    endtask

    task automatic issue(input logic [31:0] ins, output int stalls);
        bit st;
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(ins, st);
            if (!st) return;
            stalls++;
        end
        chk("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic seq2(input logic [31:0] a, input logic [31:0] b, input int exp_stalls,
                        input string nm);
        int s;
        issue(a, s);
        issue(b, s);
        chk(nm, s, exp_stalls);
        for (int k = 0; k < 3; k++) issue(32'd0, s);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",    stall,    e.st);
            chk("flush_E",  flush_E,  e.st);
            chk("md_start", md_start, e.ms);
            chk("md_busy",  md_busy,  e.mb);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, a, b, c, pick;
        bit st;
        logic [31:0] ins, mflo3;
        model_reset();
        mflo3 = r_ins(0, 3, 3, FN_MFLO);

        #2;
        chk("rst_stall",    stall,    0);
        chk("rst_flush",    flush_E,  0);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_busy",  md_busy,  0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        seq2(i_ins(OP_LW, 0, 1),  r_ins(1, 3, 2, FN_ADDU), 1, "lw_addu");
        seq2(i_ins(OP_LW, 0, 1),  i_ins(OP_BEQ, 1, 2),     2, "lw_beq");
        seq2(r_ins(4, 5, 1, FN_ADDU), i_ins(OP_BEQ, 1, 0), 1, "addu_beq");
        seq2(i_ins(OP_LW, 0, 5),  i_ins(OP_SW, 6, 5),      0, "lw_sw_rt");
        seq2({OP_JAL, 26'h40},    r_ins(31, 0, 0, FN_JR),  0, "jal_jr");
        seq2(r_ins(1, 2, 0, FN_ADDU), i_ins(OP_BEQ, 0, 0), 0, "reg0");
        seq2(i_ins(OP_LUI, 0, 4), i_ins(OP_ORI, 4, 4),     0, "lui_ori");
        seq2(r_ins(1, 2, 0, FN_MULT), mflo3, MULT_CYCLES + 1, "mult_mflo");
        seq2(r_ins(1, 2, 0, FN_DIV),  mflo3, DIV_CYCLES + 1,  "div_mflo");

        // GPR hazard hidden under an md hazard: one stall window, not two
        issue(r_ins(1, 2, 0, FN_MULT), s);
        issue(i_ins(OP_LW, 0, 7), s);
        issue(r_ins(7, 0, 0, FN_MTHI), s);
        chk("md_gpr_overlap", s, MULT_CYCLES);
        for (int k = 0; k < 3; k++) issue(32'd0, s);

        // Reset in the middle of a div countdown (counter at 7)
        issue(r_ins(1, 2, 0, FN_DIV), s);
        for (int k = 0; k < 4; k++) cycle(mflo3, st);
        D_Instr = mflo3; #1;
        chk("pre_rst_busy",  md_busy, 1);
        chk("pre_rst_stall", stall,   1);
        reset = 1'b1; #1;
        chk("mid_rst_busy",  md_busy,  0);
        chk("mid_rst_stall", stall,    0);
        chk("mid_rst_start", md_start, 0);
        model_reset();
        exp_q.push_back(exp_t'(3'b000));
        #3; reset = 1'b0;
        @(posedge clk); #1;
        model_commit(mflo3, 1'b0);
        issue(mflo3, s);
        chk("post_rst_mflo", s, 0);
        for (int k = 0; k < 3; k++) issue(32'd0, s);

        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 7); b = $urandom_range(0, 7); c = $urandom_range(0, 7);
            pick = $urandom_range(0, 17);
            case (pick)
                0:  ins = r_ins(a, b, c, FN_ADDU);
                1:  ins = r_ins(a, b, c, FN_SUBU);
                2:  ins = r_ins(a, 0, 0, FN_JR);
                3:  ins = r_ins(a, b, 0, FN_MULT);
                4:  ins = r_ins(a, b, 0, FN_DIV);
                5:  ins = r_ins(0, b, b, FN_MFHI);
                6:  ins = r_ins(0, b, b, FN_MFLO);
                7:  ins = r_ins(a, 0, 0, FN_MTHI);
                8:  ins = r_ins(a, 0, 0, FN_MTLO);
                9:  ins = i_ins(OP_ORI, a, b);
                10: ins = i_ins(OP_LW, a, b);
                11: ins = i_ins(OP_SW, a, b);
                12: ins = i_ins(OP_BEQ, a, b);
                13: ins = i_ins(OP_LUI, 0, b);
                14: ins = {OP_JAL, 26'h80};
                15: ins = {OP_J, 26'h80};
                16: ins = 32'd0;
                default: ins = {6'h3f, 26'($urandom)};
            endcase
            issue(ins, s);
        end

        D_Instr = 32'd0;
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
